multi_max_pulse: RTL and testbench
==================================

Name: multi_max_pulse

Overview:
- N-channel, W-bit successor of the two-channel 8-bit max/pulse-length unit.
- Collects one word per channel through a shared dav/rfd handshake and selects the maximum or the minimum, as chosen by `mode`.
- Drives `out` high for exactly that many clock cycles.
- Sits between producer units and a downstream pulse consumer; one transaction in flight at a time.

Parameters:
- N, 2, number of input channels (N >= 2)
- W, 8, data width per channel and pulse-counter width

Ports:
- clock  input  1  single system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- dav  input  N  data-valid per channel, bit i qualifies channel i
- x  input  N*W  channel data, channel i at bits [i*W+W-1 : i*W]
- mode  input  1  0 = select maximum, 1 = select minimum (unsigned compare)
- rfd  output  1  ready-for-data, common to all channels
- out  output  1  pulse output, high for V cycles per transaction
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values (asynchronous on reset=1):
  - state = IDLE, rfd = 1, out = 0, busy = 0, COUNT = 0, captured value V = 0.
- Selection:
  - Combinational N-way unsigned compare tree over x, using borrow-based W-bit comparison.
  - mode=0 gives the largest channel value, mode=1 the smallest.
  - Ties: any equal value is acceptable, since the result is identical.
- IDLE:
  - rfd=1, out=0.
  - When all N dav bits = 1 at a rising edge: V <= selected(x, mode), rfd <= 0, go to ACK.
  - Partial dav (some but not all bits high): remain in IDLE, capture nothing.
  - `mode` is sampled on the same edge as x.
- ACK:
  - rfd=0, out=0.
  - Wait until all N dav bits = 0.
  - On that edge:
    - V != 0: COUNT <= V, out <= 1, go to PULSE.
    - V == 0: rfd <= 1, go to IDLE; out never rises.
  - x, mode and dav changes other than the all-low condition are ignored.
- PULSE:
  - out=1, rfd=0.
  - Each edge: COUNT <= COUNT-1.
  - When COUNT == 1: out <= 0, rfd <= 1, go to IDLE.
  - out is high for exactly V consecutive cycles, from 1 up to 2^W-1.
  - dav activity during PULSE is ignored. A producer raising dav early is served only after return to IDLE, when rfd=1.
- Latency:
  - From the all-dav-low edge in ACK to the first out=1 cycle: 1 clock (registered).
  - From the last out=1 cycle to rfd=1: 0 cycles; rfd rises on the same edge that out falls.
- Outputs are registered: rfd, out and busy are driven from flops or decoded from the state register only, with no combinational path from inputs.
- No wrap-around: COUNT never decrements below 1 in PULSE.
- Reset asserted mid-ACK or mid-PULSE: immediate return to reset values; the in-progress pulse is truncated and no residual count survives.

Optional Feature:
- Macro: MULTI_MAX_PULSE_DONE_EN
- Defined: adds output port `done` (1 bit, reset 0). `done` is high for exactly one cycle, namely the first cycle back in IDLE after a completed transaction. This includes V == 0 transactions, where it follows the ACK->IDLE edge. It is not raised after a reset-aborted transaction.
- Undefined: no `done` port and no associated logic; all other behaviour is identical.

Test Plan:
- N=2, W=8, mode=0, x0=5, x1=3, both dav high then low -> rfd falls after capture; out high exactly 5 cycles; rfd returns 1 on out's falling edge.
- N=4, W=8, mode=1, x={200,7,45,9} -> out high exactly 7 cycles, busy high from capture through the last out cycle.
- dav=2'b01 held 10 cycles, then 2'b11 with x0=x1=0 -> no capture during the partial phase; after dav low, out stays 0; FSM back in IDLE with rfd=1 (done pulses once if MULTI_MAX_PULSE_DONE_EN).
- W=8, x0=255, x1=254, mode=0 -> out high exactly 255 cycles, no wrap, COUNT ends at 1.
- reset pulsed high at the 3rd cycle of a 10-cycle pulse -> out=0, rfd=1, busy=0 immediately. A following transaction with V=4 yields exactly 4 out cycles.
- dav raised again during PULSE with new x=9 -> ignored until IDLE; captured after rfd=1, giving a second pulse of 9 cycles.

Source files
------------

// File: rtl/multi_max_pulse.sv
// N-channel max/min selector that emits a pulse on `out` lasting V cycles, where V is the selected value.
// Optional macro MULTI_MAX_PULSE_DONE_EN adds a one-cycle `done` strobe after each completed transaction.
//
// state | meaning
// IDLE  | rfd=1, waiting for all dav bits high to capture the selected value
// ACK   | value captured, waiting for all dav bits low
// PULSE | out=1, counting down from the captured value to 1
module multi_max_pulse #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   dav,
    input  logic [N*W-1:0] x,
    input  logic           mode,
    output logic           rfd,
    output logic           out,
`ifdef MULTI_MAX_PULSE_DONE_EN
    output logic           done,
`endif
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   value;
    logic [W-1:0]   count;
    logic [W-1:0]   sel;
    logic           all_hi;
    logic           all_lo;
    logic           value_zero;
    logic           count_last;

    assign all_hi     = &dav;
    assign all_lo     = ~|dav;
    assign value_zero = (value == '0);
    assign count_last = (count == W'(1));

    // The borrow out of the extended subtraction is the unsigned a < b flag.
    function automatic logic less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[W];
    endfunction

    always_comb begin
        sel = x[W-1:0];
        for (int i = 1; i < N; i++) begin
            if (mode ? less(x[i*W +: W], sel) : less(sel, x[i*W +: W]))
                sel = x[i*W +: W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (all_hi) state_nxt = ACK;
            ACK:     if (all_lo) state_nxt = value_zero ? IDLE : PULSE;
            PULSE:   if (count_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rfd  = (state == IDLE);
        out  = (state == PULSE);
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && all_hi)
                value <= sel;
            if (state == ACK && all_lo && !value_zero)
                count <= value;
            else if (state == PULSE && !count_last)
                count <= count - W'(1);
        end
    end

`ifdef MULTI_MAX_PULSE_DONE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            done <= 1'b0;
        else
            done <= (state == ACK && all_lo && value_zero) ||
                    (state == PULSE && count_last);
    end
`endif

endmodule

// File: tb/tb_multi_max_pulse.sv
// Directed bench for multi_max_pulse: a vector table of two-channel transactions plus corner-case sequences.
// A four-channel instance covers the wider minimum-select case.
module tb_multi_max_pulse;

    logic        clock;
    logic        reset;
    logic [1:0]  dav2;
    logic [15:0] x2;
    logic        mode2;
    logic        rfd2, out2, busy2;
    logic [3:0]  dav4;
    logic [31:0] x4;
    logic        mode4;
    logic        rfd4, out4, busy4;
`ifdef MULTI_MAX_PULSE_DONE_EN
    logic        done2, done4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    multi_max_pulse #(.N(2), .W(8)) u_dut2 (
        .clock(clock), .reset(reset), .dav(dav2), .x(x2), .mode(mode2),
        .rfd(rfd2), .out(out2),
`ifdef MULTI_MAX_PULSE_DONE_EN
        .done(done2),
`endif
        .busy(busy2)
    );

    multi_max_pulse #(.N(4), .W(8)) u_dut4 (
        .clock(clock), .reset(reset), .dav(dav4), .x(x4), .mode(mode4),
        .rfd(rfd4), .out(out4),
`ifdef MULTI_MAX_PULSE_DONE_EN
        .done(done4),
`endif
        .busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counts consecutive out2=1 samples from the current negedge; bounded so a stuck out cannot hang.
    task automatic wait_pulse2(output int len);
        len = 0;
        while (out2 === 1'b1 && len < 300) begin
            check("rfd2_low_in_pulse", rfd2, 1'b0);
            len++;
            @(negedge clock);
        end
    endtask

    // Full two-channel transaction starting at a negedge in IDLE.
    task automatic txn2(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input int exp, input string name);
        int len;
        x2 = {b, a}; mode2 = m; dav2 = 2'b11;
        @(negedge clock);
        check({name, "_rfd_after_capture"}, rfd2, 1'b0);
        check({name, "_busy_after_capture"}, busy2, 1'b1);
        x2 = 16'hffff; mode2 = ~m;
        dav2 = 2'b00;
        @(negedge clock);
        wait_pulse2(len);
        check({name, "_len"}, len, exp);
        check({name, "_rfd_back"}, rfd2, 1'b1);
        check({name, "_busy_back"}, busy2, 1'b0);
`ifdef MULTI_MAX_PULSE_DONE_EN
        check({name, "_done"}, done2, 1'b1);
        @(negedge clock);
        check({name, "_done_clear"}, done2, 1'b0);
`endif
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        int         exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int len, l2;
        tbl[0] = '{8'd5,   8'd3,   1'b0, 5};
        tbl[1] = '{8'd5,   8'd3,   1'b1, 3};
        tbl[2] = '{8'h80,  8'h7f,  1'b0, 128};
        tbl[3] = '{8'h80,  8'h7f,  1'b1, 127};
        tbl[4] = '{8'd1,   8'd0,   1'b0, 1};
        tbl[5] = '{8'd10,  8'd10,  1'b1, 10};
        tbl[6] = '{8'd0,   8'd7,   1'b0, 7};
        tbl[7] = '{8'd0,   8'd7,   1'b1, 0};
        tbl[8] = '{8'd255, 8'd254, 1'b0, 255};

        reset = 1'b1; dav2 = '0; x2 = '0; mode2 = 1'b0;
        dav4 = '0; x4 = '0; mode4 = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_rfd", rfd2, 1'b1);
        check("reset_out", out2, 1'b0);
        check("reset_busy", busy2, 1'b0);
`ifdef MULTI_MAX_PULSE_DONE_EN
        check("reset_done", done2, 1'b0);
`endif
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 9; i++)
            txn2(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp, $sformatf("vec%0d", i));

        // Partial dav must not capture.
        x2 = {8'd50, 8'd60}; dav2 = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("partial_rfd", rfd2, 1'b1);
            check("partial_busy", busy2, 1'b0);
        end
        txn2(8'd0, 8'd0, 1'b0, 0, "zero_after_partial");

        // Four-channel minimum select with busy held through the pulse.
        x4 = {8'd9, 8'd45, 8'd7, 8'd200}; mode4 = 1'b1; dav4 = 4'hf;
        @(negedge clock);
        check("n4_rfd_capture", rfd4, 1'b0);
        check("n4_busy_capture", busy4, 1'b1);
        dav4 = 4'h0;
        @(negedge clock);
        len = 0;
        while (out4 === 1'b1 && len < 300) begin
            check("n4_busy_pulse", busy4, 1'b1);
            len++;
            @(negedge clock);
        end
        check("n4_len", len, 7);
        check("n4_rfd_back", rfd4, 1'b1);
        check("n4_busy_back", busy4, 1'b0);

        // Reset in the 3rd cycle of a 10-cycle pulse.
        x2 = {8'd10, 8'd2}; mode2 = 1'b0; dav2 = 2'b11;
        @(negedge clock);
        dav2 = 2'b00;
        repeat (3) @(negedge clock);
        check("pre_reset_out", out2, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_out", out2, 1'b0);
        check("abort_rfd", rfd2, 1'b1);
        check("abort_busy", busy2, 1'b0);
        @(negedge clock);
        reset = 1'b0;
`ifdef MULTI_MAX_PULSE_DONE_EN
        check("abort_done", done2, 1'b0);
`endif
        @(negedge clock);
        txn2(8'd4, 8'd1, 1'b0, 4, "after_reset");

        // dav raised during PULSE is served only after return to IDLE.
        x2 = {8'd2, 8'd6}; mode2 = 1'b0; dav2 = 2'b11;
        @(negedge clock);
        dav2 = 2'b00;
        @(negedge clock);
        len = 0;
        repeat (2) begin
            if (out2 === 1'b1) len++;
            @(negedge clock);
        end
        x2 = {8'd1, 8'd9}; dav2 = 2'b11;
        wait_pulse2(l2);
        check("early_dav_first_len", len + l2, 6);
        check("early_dav_rfd_back", rfd2, 1'b1);
        @(negedge clock);
        check("early_dav_captured", rfd2, 1'b0);
        dav2 = 2'b00;
        @(negedge clock);
        wait_pulse2(len);
        check("early_dav_second_len", len, 9);
        check("early_dav_idle", rfd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
